power_step_sequencer: RTL and testbench



---
 rtl/power_step_sequencer.sv | 159 +++++++++++++++
 tb/tb_power_step_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_step_sequencer.sv
// Power-step load sequencer: holds the load blocks in reset, then ramps their
// toggle rate from a start percentage to an end percentage in fixed-dwell steps.
//
// state | meaning
// IDLE  | quiescent, loads held in reset, waiting for a start edge
// ARM   | loads held in reset for ARM_CYCLES before the ramp
// RAMP  | stepping toggle_rate toward the end rate, dwell cycles per rate
// DONE  | ramp finished, loads idle but out of reset, waiting for restart
module power_step_sequencer #(
  parameter int ARM_CYCLES = 16,
  parameter int DWELL_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [6:0]         cfg_start_rate,
  input  logic [6:0]         cfg_end_rate,
  input  logic [6:0]         cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [2:0]         cfg_en_mask,
  output logic               load_rst,
  output logic [6:0]         toggle_rate,
  output logic [2:0]         load_en,
  output logic               busy,
  output logic               done,
  output logic [7:0]         step_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RAMP, S_DONE} state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic               start_q;
  logic               edge_ok;
  logic               start_edge;
  logic [7:0]         arm_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [6:0]         start_rate_q;
  logic [6:0]         end_rate_q;
  logic [6:0]         step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [2:0]         mask_q;
  logic [7:0]         rate_cur;
  logic [7:0]         rate_end8;
  logic [7:0]         step8;
  logic [7:0]         rate_up;
  logic [7:0]         rate_nxt;

  function automatic logic [6:0] clamp_rate(input logic [6:0] r);
    return (r > 7'd100) ? 7'd100 : r;
  endfunction

  // edge_ok masks the first cycle after reset so a start held high through
  // release is not mistaken for a fresh request
  assign start_edge = start & ~start_q & edge_ok;

  assign rate_cur  = {1'b0, toggle_rate};
  assign rate_end8 = {1'b0, end_rate_q};
  assign step8     = {1'b0, step_q};
  assign rate_up   = rate_cur + step8;

  // one step toward the end rate, landing exactly on it rather than passing it
  always_comb begin
    rate_nxt = rate_end8;
    if (rate_end8 > rate_cur) begin
      if (rate_up < rate_end8) rate_nxt = rate_up;
    end else if ((rate_cur - rate_end8) > step8) begin
      rate_nxt = rate_cur - step8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      edge_ok      <= 1'b0;
      load_rst     <= 1'b1;
      toggle_rate  <= '0;
      load_en      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_idx     <= '0;
      arm_cnt      <= '0;
      dwell_cnt    <= '0;
      start_rate_q <= '0;
      end_rate_q   <= '0;
      step_q       <= 7'd1;
      dwell_q      <= DWELL_ONE;
      mask_q       <= '0;
    end else begin
      start_q <= start;
      edge_ok <= 1'b1;
      if (abort) begin
        state       <= S_IDLE;
        load_rst    <= 1'b1;
        toggle_rate <= '0;
        load_en     <= '0;
        busy        <= 1'b0;
        done        <= 1'b0;
        step_idx    <= '0;
        arm_cnt     <= '0;
        dwell_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_edge) begin
              start_rate_q <= clamp_rate(cfg_start_rate);
              end_rate_q   <= clamp_rate(cfg_end_rate);
              step_q       <= (cfg_step == 7'd0) ? 7'd1 : cfg_step;
              dwell_q      <= (cfg_dwell == '0) ? DWELL_ONE : cfg_dwell;
              mask_q       <= cfg_en_mask;
              state        <= S_ARM;
              load_rst     <= 1'b1;
              toggle_rate  <= '0;
              load_en      <= '0;
              busy         <= 1'b1;
              done         <= 1'b0;
              step_idx     <= '0;
              arm_cnt      <= 8'(ARM_CYCLES - 1);
            end
          end
          S_ARM: begin
            if (arm_cnt == 8'd0) begin
              state       <= S_RAMP;
              load_rst    <= 1'b0;
              toggle_rate <= start_rate_q;
              load_en     <= mask_q;
              step_idx    <= '0;
              dwell_cnt   <= dwell_q - DWELL_ONE;
            end else begin
              arm_cnt <= arm_cnt - 8'd1;
            end
          end
          S_RAMP: begin
            if (dwell_cnt == '0) begin
              if (toggle_rate == end_rate_q) begin
                state       <= S_DONE;
                toggle_rate <= '0;
                load_en     <= '0;
                busy        <= 1'b0;
                done        <= 1'b1;
              end else begin
                toggle_rate <= 7'(rate_nxt);
                if (step_idx != 8'hFF) step_idx <= step_idx + 8'd1;
                dwell_cnt <= dwell_q - DWELL_ONE;
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_power_step_sequencer.sv
// Bench for power_step_sequencer: directed table runs, hand-written abort and
// reset sequences, and randomized runs checked cycle by cycle against a ramp model.
module tb_power_step_sequencer;
  localparam int ARM = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [6:0]  cfg_start_rate, cfg_end_rate, cfg_step;
  logic [31:0] cfg_dwell;
  logic [2:0]  cfg_en_mask;
  logic        load_rst, busy, done;
  logic [6:0]  toggle_rate;
  logic [2:0]  load_en;
  logic [7:0]  step_idx;

  int total = 0;
  int bad   = 0;

  power_step_sequencer #(.ARM_CYCLES(ARM), .DWELL_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_start_rate(cfg_start_rate), .cfg_end_rate(cfg_end_rate),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_en_mask(cfg_en_mask),
    .load_rst(load_rst), .toggle_rate(toggle_rate), .load_en(load_en),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // idx < 0 means step_idx is not checked on that cycle
  typedef struct { bit lrst; int rate; int en; bit bsy; bit dn; int idx; } exp_t;
  exp_t exp_q[$];

  typedef struct { int s; int e; int st; int dw; int mask; int eff_dw; int n;
                   int r0; int r1; int r2; int r3; } vec_t;
  vec_t tbl[5];

  task automatic chk(input string what, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", what, act, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " load_rst"}, int'(load_rst), 1);
    chk({tag, " rate"}, int'(toggle_rate), 0);
    chk({tag, " load_en"}, int'(load_en), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " step_idx"}, int'(step_idx), 0);
  endtask

  task automatic check_exp(input exp_t x, input string tag, input int cyc);
    string p;
    p = $sformatf("%s c%0d", tag, cyc);
    chk({p, " load_rst"}, int'(load_rst), int'(x.lrst));
    chk({p, " rate"}, int'(toggle_rate), x.rate);
    chk({p, " load_en"}, int'(load_en), x.en);
    chk({p, " busy"}, int'(busy), int'(x.bsy));
    chk({p, " done"}, int'(done), int'(x.dn));
    if (x.idx >= 0) chk({p, " step_idx"}, int'(step_idx), x.idx);
  endtask

  function automatic void push_arm();
    exp_q.delete();
    for (int i = 0; i < ARM; i++) exp_q.push_back('{1'b1, 0, 0, 1'b1, 1'b0, 0});
  endfunction

  function automatic void build_from_table(input vec_t v);
    int r[4];
    r = '{v.r0, v.r1, v.r2, v.r3};
    push_arm();
    for (int k = 0; k < v.n; k++)
      for (int d = 0; d < v.eff_dw; d++) exp_q.push_back('{1'b0, r[k], v.mask, 1'b1, 1'b0, k});
    exp_q.push_back('{1'b0, 0, 0, 1'b0, 1'b1, -1});
  endfunction

  // Reference ramp: clamp the config, then walk the rate toward the end value
  function automatic void build_model(input int s, input int e, input int st, input int dw, input int mask);
    int r, fin, stp, dwl, idx;
    push_arm();
    r   = (s > 100) ? 100 : s;
    fin = (e > 100) ? 100 : e;
    stp = (st == 0) ? 1 : st;
    dwl = (dw == 0) ? 1 : dw;
    idx = 0;
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < dwl; d++)
        exp_q.push_back('{1'b0, r, mask, 1'b1, 1'b0, (idx > 255) ? 255 : idx});
      if (r == fin) break;
      if (r < fin) r = (r + stp > fin) ? fin : r + stp;
      else         r = (r - stp < fin) ? fin : r - stp;
      idx++;
    end
    exp_q.push_back('{1'b0, 0, 0, 1'b0, 1'b1, -1});
  endfunction

  task automatic set_cfg(input int s, input int e, input int st, input int dw, input int mask);
    cfg_start_rate = 7'(s);
    cfg_end_rate   = 7'(e);
    cfg_step       = 7'(st);
    cfg_dwell      = 32'(dw);
    cfg_en_mask    = 3'(mask);
  endtask

  // Caller has start low for at least one edge; raises start, then walks exp_q
  task automatic run_trace(input int s, input int e, input int st, input int dw,
                           input int mask, input bit disturb, input string tag);
    int last;
    set_cfg(s, e, st, dw, mask);
    start = 1'b1;
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      check_exp(exp_q[i], tag, i);
      if (i == last) start = 1'b0;
      else if (disturb) begin
        set_cfg($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
                $urandom_range(0, 5), $urandom_range(0, 7));
        start = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    chk({tag, " done_hold"}, int'(done), 1);
    chk({tag, " done_busy"}, int'(busy), 0);
    chk({tag, " done_rate"}, int'(toggle_rate), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, e, st, dw, m;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("idle");

    tbl[0] = '{10, 40, 10, 4, 7, 4, 4, 10, 20, 30, 40};
    tbl[1] = '{50, 5, 20, 2, 1, 2, 4, 50, 30, 10, 5};
    tbl[2] = '{120, 120, 0, 0, 2, 1, 1, 100, 0, 0, 0};
    tbl[3] = '{0, 127, 127, 1, 5, 1, 2, 0, 100, 0, 0};
    tbl[4] = '{100, 0, 60, 3, 6, 3, 3, 100, 40, 0, 0};
    for (int t = 0; t < 5; t++) begin
      build_from_table(tbl[t]);
      run_trace(tbl[t].s, tbl[t].e, tbl[t].st, tbl[t].dw, tbl[t].mask, 1'b0,
                $sformatf("tbl%0d", t));
    end

    // abort mid-RAMP, then abort together with a start edge
    set_cfg(10, 40, 10, 4, 7);
    start = 1'b1;
    repeat (ARM + 2) @(negedge clk);
    chk("abort pre busy", int'(busy), 1);
    chk("abort pre rate", int'(toggle_rate), 10);
    abort = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk_idle("abort+start");
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort hold%0d busy", i), int'(busy), 0);
      chk($sformatf("abort hold%0d load_rst", i), int'(load_rst), 1);
    end
    start = 1'b0;
    @(negedge clk);

    // cfg changes and start re-pulses during the run must not disturb it
    build_model(10, 40, 10, 4, 7);
    run_trace(10, 40, 10, 4, 7, 1'b1, "latch");

    for (int r = 0; r < 12; r++) begin
      s = $urandom_range(0, 127);
      e = $urandom_range(0, 127);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 127);
      dw = $urandom_range(0, 3);
      m = $urandom_range(0, 7);
      build_model(s, e, st, dw, m);
      run_trace(s, e, st, dw, m, r[0], $sformatf("rnd%0d", r));
    end

    // async reset between edges during RAMP, start held high across release
    set_cfg(10, 40, 10, 4, 7);
    start = 1'b1;
    repeat (ARM + 3) @(negedge clk);
    chk("arst pre rate", int'(toggle_rate), 10);
    #2 rst = 1'b1;
    #1 chk_idle("arst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("arst hold%0d busy", i), int'(busy), 0);
      chk($sformatf("arst hold%0d load_rst", i), int'(load_rst), 1);
    end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("arst restart busy", int'(busy), 1);
    chk("arst restart load_rst", int'(load_rst), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
